rmap_cmd_encoder: RTL

RMAP_CMD_ENCODER -- requirements
Module: rmap_cmd_encoder

---
 rtl/rmap_cmd_encoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rmap_cmd_encoder.sv
// RMAP write-command encoder: turns one write request into a TX FIFO character
// stream (header, header CRC, 4 data bytes, data CRC, EOP).
module rmap_cmd_encoder #(
   parameter logic [7:0] PROTOCOL_ID = 8'h01
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqData,
   input  logic [15:0] reqTransId,
   input  logic [7:0]  reqKey,
   input  logic        reqVerify,
   input  logic        reqReply,
   input  logic        reqIncrement,
   input  logic [1:0]  reqReplyAddrLen,
   input  logic [95:0] reqReplyAddr,
   input  logic [7:0]  targetLogAddr,
   input  logic [7:0]  initiatorLogAddr,
   output logic        txWriteEnable,
   output logic [8:0]  txDataIn,
   input  logic        txFull,
   output logic        busy,
   output logic [15:0] pktCount
);

   typedef enum logic [2:0] {IDLE, HEADER, HCRC, DATA, DCRC, EOP} state_t;

   state_t      state, stateNext;
   logic [4:0]  byteIdx, byteIdxNext;
   logic [7:0]  crc, crcNext;
   logic        readyEn;
   logic        accept;

   logic [7:0]  tgtLa, initLa, instr, key;
   logic [15:0] transId;
   logic [31:0] addr, data;
   logic [1:0]  rplLen;
   logic [95:0] rplAligned;

   logic [4:0]  rplBytes, hdrLast, rplOff, tailOff;
   logic [7:0]  hdrByte, dataByte, txByte;
   logic        txFlag;

   function automatic logic [7:0] crc8Byte(input logic [7:0] crcIn, input logic [7:0] d);
      logic [7:0] c;
      c = crcIn;
      for (int unsigned b = 0; b < 8; b++) begin
         if (c[0] ^ d[b]) c = (c >> 1) ^ 8'hE0;
         else             c = c >> 1;
      end
      return c;
   endfunction

   assign busy          = (state != IDLE);
   assign reqReady      = (state == IDLE) && readyEn;
   assign accept        = reqValid && reqReady;
   assign txWriteEnable = busy && !txFull;
   assign txDataIn      = {txFlag, txByte};

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state    <= IDLE;
         byteIdx  <= '0;
         crc      <= '0;
         pktCount <= '0;
         readyEn  <= 1'b0;
      end else begin
         state    <= stateNext;
         byteIdx  <= byteIdxNext;
         crc      <= crcNext;
         readyEn  <= 1'b1;
         if (state == EOP && txWriteEnable) pktCount <= pktCount + 16'd1;
      end
   end

   // Reply address is left-aligned at capture so byte k is always at the top minus 8*k.
   always_ff @(posedge clk) begin
      if (accept) begin
         tgtLa   <= targetLogAddr;
         initLa  <= initiatorLogAddr;
         instr   <= {2'b01, 1'b1, reqVerify, reqReply, reqIncrement, reqReplyAddrLen};
         key     <= reqKey;
         transId <= reqTransId;
         addr    <= reqAddr;
         data    <= reqData;
         rplLen  <= reqReplyAddrLen;
         case (reqReplyAddrLen)
            2'd0:    rplAligned <= '0;
            2'd1:    rplAligned <= {reqReplyAddr[31:0], 64'h0};
            2'd2:    rplAligned <= {reqReplyAddr[63:0], 32'h0};
            default: rplAligned <= reqReplyAddr;
         endcase
      end
   end

   assign rplBytes = {1'b0, rplLen, 2'b00};
   assign hdrLast  = 5'd14 + rplBytes;
   assign rplOff   = byteIdx - 5'd4;
   assign tailOff  = byteIdx - 5'd4 - rplBytes;

   always_comb begin
      hdrByte = '0;
      if (byteIdx < 5'd4) begin
         case (byteIdx[1:0])
            2'd0:    hdrByte = tgtLa;
            2'd1:    hdrByte = PROTOCOL_ID;
            2'd2:    hdrByte = instr;
            default: hdrByte = key;
         endcase
      end else if (byteIdx < 5'd4 + rplBytes) begin
         hdrByte = rplAligned[8'd95 - {rplOff, 3'b000} -: 8];
      end else begin
         case (tailOff)
            5'd0:    hdrByte = initLa;
            5'd1:    hdrByte = transId[15:8];
            5'd2:    hdrByte = transId[7:0];
            5'd4:    hdrByte = addr[31:24];
            5'd5:    hdrByte = addr[23:16];
            5'd6:    hdrByte = addr[15:8];
            5'd7:    hdrByte = addr[7:0];
            5'd10:   hdrByte = 8'h04;
            default: hdrByte = 8'h00;
         endcase
      end
   end

   always_comb begin
      case (byteIdx[1:0])
         2'd0:    dataByte = data[31:24];
         2'd1:    dataByte = data[23:16];
         2'd2:    dataByte = data[15:8];
         default: dataByte = data[7:0];
      endcase
   end

   always_comb begin
      txByte = '0;
      txFlag = 1'b0;
      case (state)
         HEADER:  txByte = hdrByte;
         HCRC:    txByte = crc;
         DATA:    txByte = dataByte;
         DCRC:    txByte = crc;
         EOP:     txFlag = 1'b1;
         default: txByte = '0;
      endcase
   end

   // CRC folds in each byte as it is written, so the CRC states can emit it directly.
   always_comb begin
      stateNext   = state;
      byteIdxNext = byteIdx;
      crcNext     = crc;
      if (state == IDLE) begin
         if (accept) begin
            stateNext   = HEADER;
            byteIdxNext = '0;
            crcNext     = '0;
         end
      end else if (txWriteEnable) begin
         case (state)
            HEADER: begin
               crcNext = crc8Byte(crc, txByte);
               if (byteIdx == hdrLast) begin
                  stateNext   = HCRC;
                  byteIdxNext = '0;
               end else begin
                  byteIdxNext = byteIdx + 5'd1;
               end
            end
            HCRC: begin
               crcNext     = '0;
               byteIdxNext = '0;
               stateNext   = DATA;
            end
            DATA: begin
               crcNext = crc8Byte(crc, txByte);
               if (byteIdx == 5'd3) begin
                  stateNext   = DCRC;
                  byteIdxNext = '0;
               end else begin
                  byteIdxNext = byteIdx + 5'd1;
               end
            end
            DCRC: begin
               crcNext   = '0;
               stateNext = EOP;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

endmodule
